pipelined_adder_nbit: RTL and testbench
=======================================

Name: pipelined_adder_nbit

Overview:
- Parametrised, pipelined successor to the 16-bit carry-ripple adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple slices, one slice per register stage.
- Carry passes between stages; operand and sum slices are skewed and deskewed so results emerge aligned.
- Valid/ready streaming handshake with full backpressure; sits in datapaths that need throughput above a single-cycle ripple.

Parameters:
- WIDTH, 16, operand/sum width in bits.
- STAGES, 4, number of pipeline stages (= slices). WIDTH % STAGES must be 0; otherwise elaboration error.
- SLICE_W, WIDTH/STAGES, derived local slice width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out; for sub=1, 1 = no borrow (a >= b unsigned).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (rst). While rst=1, all stage valid bits, sum, cout and internal data registers are 0, and out_valid=0 immediately.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Global advance = out_ready || !out_valid; in_ready = advance, which is combinational from out_ready.
- On advance, every stage loads from the previous stage. Stage 0 loads from inputs with valid = in_valid. When advance=0, all registers hold.
- Stage k (0-based) contents:
  - computes slice k = a[k] + b'[k] + carry_in, where b' = sub ? ~b : b;
  - stage 0 carry_in = sub ? 1 : cin;
  - stores sum slices 0..k, carry out of slice k, and raw a/b' slices k+1..STAGES-1.
- Latency: exactly STAGES cycles from input transfer to out_valid with no stall. Throughput is 1 result per cycle.
- sum and cout come from the last stage and are held stable while out_valid && !out_ready.
- Bubbles (in_valid=0) propagate as invalid stages. Bubbles are squeezed only when the last stage is empty, per the advance rule. Order is strictly preserved.
- Simultaneous input accept and output drain in one cycle is allowed and required for full throughput.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full result.
- STAGES=1 degenerates to a single registered adder with latency 1.
- Reset mid-stream discards all in-flight beats. After rst falls, the first out_valid appears only STAGES cycles after a new input transfer.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow of the operation = carry into MSB XOR carry out of MSB. It is pipelined alongside sum, valid with out_valid, and resets to 0.
- Undefined: no ovf port and no extra registers.

Decomposition:
- Shared package adder_pkg holds:
  - localparam defaults ADDER_WIDTH_DEF=16 and ADDER_STAGES_DEF=4;
  - function slice_lo(k, SLICE_W) returning the bit offset of slice k.
- One natural sub-module: adder_slice, a combinational SLICE_W-bit ripple slice (a, b, cin -> s, cout, plus carry-into-MSB for the ovf option). It is instantiated STAGES times via generate.

Test Plan (WIDTH=16, STAGES=4):
- 0x0001+0x0001, cin=0, out_ready=1 -> after 4 cycles sum=0x0002, cout=0, out_valid high for 1 cycle.
- 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1. Carry crosses all 4 slices.
- Back-to-back beats on consecutive cycles:
  - 0xAAAA+0x5555, cin=1 -> 0x0000 / cout 1;
  - 0x1234+0x5678, cin=0 -> 0x68AC / 0;
  - 0xFFFF+0xFFFF, cin=1 -> 0xFFFF / 1.
  - Results appear on consecutive cycles, in order.
- Pipeline full, out_ready low for 3 cycles -> in_ready=0, sum/cout/out_valid held stable. Beats are neither lost nor duplicated after out_ready returns.
- Subtract:
  - sub=1, 0x0005-0x0007 -> sum=0xFFFE, cout=0;
  - 0x0007-0x0005 -> 0x0002, cout=1;
  - cin=1 ignored in both.
- Assert rst with 3 beats in flight -> out_valid=0 immediately. No stale results after release. With PIPE_ADDER_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// ============================================================================
// Module  : adder_pkg
// Brief   : Shared defaults and slice-offset helper for the pipelined adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int ADDER_WIDTH_DEF  = 16;
    localparam int ADDER_STAGES_DEF = 4;

    function automatic int slice_lo(input int k, input int slice_w);
        return k * slice_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_slice.sv
// ============================================================================
// Module  : adder_slice
// Brief   : Combinational SLICE_W-bit ripple-carry slice, also exposing the
//           carry into its MSB for signed-overflow detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_slice
    import adder_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               cmsb
);

    logic [SLICE_W:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = w_c[SLICE_W];
    assign cmsb = w_c[SLICE_W-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_adder_nbit.sv
// ============================================================================
// Module  : pipelined_adder_nbit
// Brief   : WIDTH-bit add/subtract split into STAGES registered ripple slices
//           with valid/ready flow control. PIPE_ADDER_OVF_EN adds port ovf.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipelined_adder_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DEF,
    parameter int STAGES = ADDER_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SLICE_W = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0) begin : g_width_check
        $error("pipelined_adder_nbit: WIDTH must be a multiple of STAGES");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bx;
    logic             w_cin0;

    // One global enable: the whole pipe moves unless the last stage is blocked.
    assign w_adv    = out_ready || !out_valid;
    assign in_ready = w_adv;
    assign w_bx     = sub ? ~b : b;
    assign w_cin0   = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_sum_w = slice_lo(k + 1, SLICE_W);
        localparam int c_src_w = WIDTH - slice_lo(k, SLICE_W);

        logic               r_valid;
        logic               r_cy;
        logic [c_sum_w-1:0] r_sum;
        logic [c_src_w-1:0] w_src_a;
        logic [c_src_w-1:0] w_src_b;
        logic               w_vin;
        logic               w_cin;
        logic               w_co;
        logic               w_cm;
        logic [SLICE_W-1:0] w_s;
        logic [c_sum_w-1:0] w_sum_d;

        if (k == 0) begin : g_src
            assign w_src_a = a;
            assign w_src_b = w_bx;
            assign w_cin   = w_cin0;
            assign w_vin   = in_valid;
            assign w_sum_d = w_s;
        end else begin : g_src
            assign w_src_a = g_stage[k-1].g_opnd.r_a;
            assign w_src_b = g_stage[k-1].g_opnd.r_b;
            assign w_cin   = g_stage[k-1].r_cy;
            assign w_vin   = g_stage[k-1].r_valid;
            assign w_sum_d = {w_s, g_stage[k-1].r_sum};
        end

        adder_slice #(
            .SLICE_W (SLICE_W)
        ) u_slice (
            .a    (w_src_a[SLICE_W-1:0]),
            .b    (w_src_b[SLICE_W-1:0]),
            .cin  (w_cin),
            .s    (w_s),
            .cout (w_co),
            .cmsb (w_cm)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_cy    <= 1'b0;
                r_sum   <= '0;
            end else if (w_adv) begin
                r_valid <= w_vin;
                r_cy    <= w_co;
                r_sum   <= w_sum_d;
            end
        end

        // Operand slices not yet consumed travel down with the partial sum.
        if (k < STAGES - 1) begin : g_opnd
            logic [c_src_w-SLICE_W-1:0] r_a;
            logic [c_src_w-SLICE_W-1:0] r_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_src_a[c_src_w-1:SLICE_W];
                    r_b <= w_src_b[c_src_w-1:SLICE_W];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_co ^ w_cm;
                end
            end
        end else begin : g_cm_sink
            logic w_unused_cm;
            assign w_unused_cm = w_cm;
        end
`else
        logic w_unused_cm;
        assign w_unused_cm = w_cm;
`endif
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_cy;
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder_nbit.sv
// ============================================================================
// Module  : tb_pipelined_adder_nbit
// Brief   : Scoreboard bench: driver pushes reference results, monitor pops
//           and compares on every output transfer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_adder_nbit;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PIPE_ADDER_OVF_EN
    logic         ovf;
`endif

    pipelined_adder_nbit #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           issue;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
        exp_t        e;
        int unsigned r;
        int          sx;
        int          sy;
        int          sr;
        sx = $signed(x);
        sy = $signed(y);
        if (s) begin
            r  = 32'h0001_0000 + 32'(x) - 32'(y);
            sr = sx - sy;
        end else begin
            r  = 32'(x) + 32'(y) + 32'(c);
            sr = sx + sy + int'(c);
        end
        e.sum   = r[W-1:0];
        e.cout  = r[W];
        e.ovf   = (sr > 32767) || (sr < -32768);
        e.issue = 0;
        e.lat   = 1'b0;
        return e;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input logic ordy, input bit lat,
                        output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e       = ref_model(x, y, c, s);
            e.issue = cyc + 1;
            e.lat   = lat;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, acc);
    endtask

    // Monitor
    initial begin
        bit           prev_stall;
        logic [W-1:0] psum;
        logic         pcout;
        exp_t         e;
        prev_stall = 1'b0;
        psum       = '0;
        pcout      = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_sum", 32'(sum), 32'(psum));
                    chk("hold_cout", 32'(cout), 32'(pcout));
                end
                chk("in_ready_rule", 32'(in_ready), 32'(out_ready || !out_valid));
                prev_stall = out_valid && !out_ready;
                psum       = sum;
                pcout      = cout;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got sum=%0h with nothing outstanding", sum);
                    end else begin
                        e = q.pop_front();
                        chk("sum", 32'(sum), 32'(e.sum));
                        chk("cout", 32'(cout), 32'(e.cout));
`ifdef PIPE_ADDER_OVF_EN
                        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                        if (e.lat) chk("latency", 32'(cyc + 1 - e.issue), 32'(S));
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        bit           acc;
        bit           pend;
        logic [W-1:0] px;
        logic [W-1:0] py;
        logic         pc;
        logic         ps;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // Directed beats with free-flowing output
        step(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, acc); chk("acc_d0", 32'(acc), 32'd1);
        idle(1, 1'b1);
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, acc); chk("acc_d1", 32'(acc), 32'd1);
        idle(1, 1'b1);
        step(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b1, acc); chk("acc_d2", 32'(acc), 32'd1);
        step(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b1, acc); chk("acc_d3", 32'(acc), 32'd1);
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, acc); chk("acc_d4", 32'(acc), 32'd1);
        step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1, acc); chk("acc_d5", 32'(acc), 32'd1);
        step(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, 1'b1, acc); chk("acc_d6", 32'(acc), 32'd1);
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, acc); chk("acc_d7", 32'(acc), 32'd1);
        idle(S + 2, 1'b1);

        // Fill the pipe under backpressure, then stall three cycles
        for (int i = 0; i < S; i++) begin
            step(1'b1, 16'(16'h1000 * i + 3), 16'(16'h0F00 + i), 1'(i), 1'b0, 1'b0, 1'b0, acc);
            chk("fill_accept", 32'(acc), 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'hBEEF, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, acc);
            chk("stall_in_ready", 32'(acc), 32'd0);
        end
        step(1'b1, 16'hBEEF, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        chk("resume_accept", 32'(acc), 32'd1);
        idle(S + 2, 1'b1);

        // Random traffic with random backpressure; a beat is held until taken
        pend = 1'b0;
        px   = '0;
        py   = '0;
        pc   = 1'b0;
        ps   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                pend = 1'b1;
                px   = 16'($urandom);
                py   = 16'($urandom);
                pc   = 1'($urandom);
                ps   = 1'($urandom);
            end
            step(pend, px, py, pc, ps, 1'($urandom_range(0, 3) != 0), 1'b0, acc);
            if (acc) pend = 1'b0;
        end
        idle(S + 4, 1'b1);

        // Reset with the pipe full: outputs drop at once, nothing stale follows
        for (int i = 0; i < S; i++) step(1'b1, 16'h0100, 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_sum", 32'(sum), 32'd0);
        chk("async_rst_cout", 32'(cout), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(S + 3, 1'b1);
        step(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        chk("post_rst_accept", 32'(acc), 32'd1);
        idle(S + 3, 1'b1);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
